// File: rtl/ahb_lite_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ahb_lite_master_arbiter
// Function : Round-robin sharing of one AHB-Lite master port by two requesters,
//            SINGLE transfers only, with ERROR-cancel and in-order re-issue.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_lite_master_arbiter #(
    parameter int ADDRWIDTH = 32,
    parameter int DATAWIDTH = 32
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic                 req0_valid,
    input  logic                 req0_write,
    input  logic [ADDRWIDTH-1:0] req0_addr,
    input  logic [2:0]           req0_size,
    input  logic [DATAWIDTH-1:0] req0_wdata,
    output logic                 req0_ready,
    output logic                 req0_done,
    output logic                 req0_err,
    output logic [DATAWIDTH-1:0] req0_rdata,
    input  logic                 req1_valid,
    input  logic                 req1_write,
    input  logic [ADDRWIDTH-1:0] req1_addr,
    input  logic [2:0]           req1_size,
    input  logic [DATAWIDTH-1:0] req1_wdata,
    output logic                 req1_ready,
    output logic                 req1_done,
    output logic                 req1_err,
    output logic [DATAWIDTH-1:0] req1_rdata,
    output logic [ADDRWIDTH-1:0] HADDR,
    output logic                 HWRITE,
    output logic [2:0]           HSIZE,
    output logic [1:0]           HTRANS,
    output logic [2:0]           HBURST,
    output logic [DATAWIDTH-1:0] HWDATA,
    input  logic [DATAWIDTH-1:0] HRDATA,
    input  logic                 HREADY,
    input  logic                 HRESP
);

    localparam logic [1:0] c_htrans_idle   = 2'b00;
    localparam logic [1:0] c_htrans_nonseq = 2'b10;
    localparam logic [2:0] c_hburst_single = 3'b000;

    // Address phase
    logic                 r_nonseq;
    logic [ADDRWIDTH-1:0] r_haddr;
    logic                 r_hwrite;
    logic [2:0]           r_hsize;
    logic [DATAWIDTH-1:0] r_ap_wdata;
    logic                 r_ap_owner;
    logic                 r_retry;
    // Data phase
    logic                 r_dp_valid;
    logic                 r_dp_owner;
    logic                 r_dp_write;
    logic [DATAWIDTH-1:0] r_hwdata;
    // Arbitration: requester that wins the next contention
    logic                 r_prefer;
    // Completion
    logic                 r_done0;
    logic                 r_done1;
    logic                 r_err0;
    logic                 r_err1;
    logic [DATAWIDTH-1:0] r_rdata0;
    logic [DATAWIDTH-1:0] r_rdata1;

    logic w_free;
    logic w_grant0;
    logic w_grant1;
    logic w_accept;
    logic w_sel;
    logic w_cancel;
    logic w_complete;

    // A retained (cancelled) transfer blocks the slot until it is re-issued.
    assign w_free     = (!r_nonseq || HREADY) && !r_retry;
    assign w_grant0   = req0_valid && (!req1_valid || !r_prefer);
    assign w_grant1   = req1_valid && (!req0_valid ||  r_prefer);
    assign req0_ready = w_grant0 && w_free && !HRESET;
    assign req1_ready = w_grant1 && w_free && !HRESET;
    assign w_accept   = req0_ready || req1_ready;
    assign w_sel      = req1_ready;
    assign w_cancel   = HRESP && !HREADY && r_dp_valid && r_nonseq;
    assign w_complete = HREADY && r_dp_valid;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_nonseq   <= 1'b0;
            r_haddr    <= '0;
            r_hwrite   <= 1'b0;
            r_hsize    <= 3'b000;
            r_ap_wdata <= '0;
            r_ap_owner <= 1'b0;
            r_retry    <= 1'b0;
            r_dp_valid <= 1'b0;
            r_dp_owner <= 1'b0;
            r_dp_write <= 1'b0;
            r_hwdata   <= '0;
            r_prefer   <= 1'b0;
            r_done0    <= 1'b0;
            r_done1    <= 1'b0;
            r_err0     <= 1'b0;
            r_err1     <= 1'b0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
        end else begin
            if (w_cancel) begin
                r_nonseq <= 1'b0;
                r_retry  <= 1'b1;
            end else if (r_retry && HREADY) begin
                r_nonseq <= 1'b1;
                r_retry  <= 1'b0;
            end else if (w_accept) begin
                r_nonseq   <= 1'b1;
                r_haddr    <= w_sel ? req1_addr  : req0_addr;
                r_hwrite   <= w_sel ? req1_write : req0_write;
                r_hsize    <= w_sel ? req1_size  : req0_size;
                r_ap_wdata <= w_sel ? req1_wdata : req0_wdata;
                r_ap_owner <= w_sel;
                r_prefer   <= ~w_sel;
            end else if (w_free) begin
                r_nonseq <= 1'b0;
            end

            if (HREADY) begin
                r_dp_valid <= r_nonseq;
                r_dp_owner <= r_ap_owner;
                r_dp_write <= r_hwrite;
                if (r_nonseq) begin
                    r_hwdata <= r_ap_wdata;
                end
            end

            r_done0  <= w_complete && !r_dp_owner;
            r_done1  <= w_complete &&  r_dp_owner;
            r_err0   <= w_complete && !r_dp_owner && HRESP;
            r_err1   <= w_complete &&  r_dp_owner && HRESP;
            r_rdata0 <= (w_complete && !r_dp_owner && !r_dp_write) ? HRDATA : '0;
            r_rdata1 <= (w_complete &&  r_dp_owner && !r_dp_write) ? HRDATA : '0;
        end
    end

    assign HADDR      = r_haddr;
    assign HWRITE     = r_hwrite;
    assign HSIZE      = r_hsize;
    assign HTRANS     = r_nonseq ? c_htrans_nonseq : c_htrans_idle;
    assign HBURST     = c_hburst_single;
    assign HWDATA     = r_hwdata;
    assign req0_done  = r_done0;
    assign req1_done  = r_done1;
    assign req0_err   = r_err0;
    assign req1_err   = r_err1;
    assign req0_rdata = r_rdata0;
    assign req1_rdata = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_master_arbiter.sv
`default_nettype none
// Bench for ahb_lite_master_arbiter: directed scenarios followed by random
// traffic against a transaction-queue model with a randomly stalling slave.
module tb_ahb_lite_master_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic          req0_valid, req0_write, req0_ready, req0_done, req0_err;
    logic [AW-1:0] req0_addr;
    logic [2:0]    req0_size;
    logic [DW-1:0] req0_wdata, req0_rdata;
    logic          req1_valid, req1_write, req1_ready, req1_done, req1_err;
    logic [AW-1:0] req1_addr;
    logic [2:0]    req1_size;
    logic [DW-1:0] req1_wdata, req1_rdata;
    logic [AW-1:0] HADDR;
    logic          HWRITE;
    logic [2:0]    HSIZE, HBURST;
    logic [1:0]    HTRANS;
    logic [DW-1:0] HWDATA, HRDATA;
    logic          HREADY, HRESP;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit            owner;
        bit            write;
        logic [AW-1:0] addr;
        logic [2:0]    size;
        logic [DW-1:0] wdata;
    } txn_t;

    ahb_lite_master_arbiter #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_size(req0_size), .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .req0_done(req0_done), .req0_err(req0_err), .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_size(req1_size), .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .req1_done(req1_done), .req1_err(req1_err), .req1_rdata(req1_rdata),
        .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HTRANS(HTRANS),
        .HBURST(HBURST), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
        .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_size = 3'd0; req0_wdata = '0;
        req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_size = 3'd0; req1_wdata = '0;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    endtask

    // Random-phase model state
    txn_t          pend[$];
    txn_t          dp;
    txn_t          t;
    bit            dp_act, retry_pend, err_stage, prefer, first_err, shown, free;
    bit            v0, v1, e0, e1;
    bit            exp_dv, exp_owner, exp_err;
    logic [DW-1:0] exp_rdata;
    int            n_acc, n_done;

    initial begin
        idle_inputs();
        HRESET = 1'b1;

        // ---------------- reset state ----------------
        tick(); tick();
        chk("rst_htrans", HTRANS, 2'b00);
        chk("rst_haddr", HADDR, 0);
        chk("rst_hwrite", HWRITE, 0);
        chk("rst_hsize", HSIZE, 0);
        chk("rst_hwdata", HWDATA, 0);
        chk("rst_hburst", HBURST, 0);
        chk("rst_dones", {req0_done, req1_done, req0_err, req1_err}, 0);
        chk("rst_rdata", {req0_rdata, req1_rdata}, 0);

        // reset while a NONSEQ is pending discards it
        HRESET = 1'b0;
        req0_valid = 1'b1; req0_addr = 32'h40; req0_size = 3'd2;
        #1; chk("pre_ready0", req0_ready, 1);
        tick();
        chk("pre_htrans", HTRANS, 2'b10);
        HRESET = 1'b1;
        #1; chk("rst_ready0_held", req0_ready, 0);
        tick();
        req0_valid = 1'b0;
        tick();
        chk("rst2_htrans", HTRANS, 2'b00);
        chk("rst2_haddr", HADDR, 0);
        chk("rst2_hsize", HSIZE, 0);
        HRESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst2_no_done", {req0_done, req1_done}, 0);
        end

        // ---------------- single write ----------------
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 32'h10; req0_size = 3'b010;
        req0_wdata = 32'hDEADBEEF;
        #1; chk("wr_ready0", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        chk("wr_htrans", HTRANS, 2'b10);
        chk("wr_haddr", HADDR, 32'h10);
        chk("wr_hwrite", HWRITE, 1);
        chk("wr_hsize", HSIZE, 3'b010);
        tick();
        chk("wr_hwdata", HWDATA, 32'hDEADBEEF);
        chk("wr_htrans_idle", HTRANS, 2'b00);
        tick();
        chk("wr_done0", req0_done, 1);
        chk("wr_err0", req0_err, 0);
        chk("wr_rdata0", req0_rdata, 0);
        tick();
        chk("wr_done_pulse", req0_done, 0);

        // ---------------- contention (fresh reset: req0 wins first) ----------------
        HRESET = 1'b1; tick(); tick(); HRESET = 1'b0;
        req0_write = 1'b0; req0_addr = 32'h0;
        req1_write = 1'b0; req1_addr = 32'h4; req1_size = 3'b010;
        for (int k = 0; k < 6; k++) begin
            req0_valid = (k < 4);
            req1_valid = (k < 4);
            HRDATA = 32'hBEEF0000 + k;
            #1;
            if (k < 4) begin
                chk("rr_ready0", req0_ready, (k % 2) == 0);
                chk("rr_ready1", req1_ready, (k % 2) == 1);
            end
            tick();
            if (k < 4) begin
                chk("rr_htrans", HTRANS, 2'b10);
                chk("rr_haddr", HADDR, (k % 2) ? 32'h4 : 32'h0);
            end
            if (k >= 2) begin
                chk("rr_done0", req0_done, (k % 2) == 0);
                chk("rr_done1", req1_done, (k % 2) == 1);
                chk("rr_rdata", (k % 2) ? req1_rdata : req0_rdata, 32'hBEEF0000 + k);
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // ---------------- wait states ----------------
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 32'h20; req0_wdata = 32'h11111111;
        #1; tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 32'h24; req1_wdata = 32'h22222222;
        #1; chk("ws_ready1", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("ws_haddr", HADDR, 32'h24);
            chk("ws_htrans", HTRANS, 2'b10);
            chk("ws_hwdata", HWDATA, 32'h11111111);
            chk("ws_no_done", {req0_done, req1_done}, 0);
            HREADY = (i == 3);
            tick();
        end
        chk("ws_done0", req0_done, 1);
        chk("ws_hwdata_b", HWDATA, 32'h22222222);
        tick();
        chk("ws_done1", req1_done, 1);
        chk("ws_done0_off", req0_done, 0);

        // ---------------- error with pending address phase ----------------
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 32'h30;
        #1; tick();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 32'h34;
        #1; chk("er_ready0", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        chk("er_htrans_a", HTRANS, 2'b10);
        HRESP = 1'b1; HREADY = 1'b0;
        tick();
        chk("er_htrans_cancel", HTRANS, 2'b00);
        chk("er_no_done", {req0_done, req1_done}, 0);
        HREADY = 1'b1;
        req1_valid = 1'b1; req1_addr = 32'h38;
        #1; chk("er_ready_blocked", {req0_ready, req1_ready}, 0);
        tick();
        req1_valid = 1'b0; HRESP = 1'b0;
        chk("er_done1", req1_done, 1);
        chk("er_err1", req1_err, 1);
        chk("er_reissue_htrans", HTRANS, 2'b10);
        chk("er_reissue_haddr", HADDR, 32'h34);
        tick();
        HRDATA = 32'h5555AAAA;
        tick();
        chk("er_done0", req0_done, 1);
        chk("er_err0", req0_err, 0);
        chk("er_rdata0", req0_rdata, 32'h5555AAAA);

        // ---------------- random traffic vs. transaction model ----------------
        idle_inputs();
        HRESET = 1'b1; tick(); tick(); HRESET = 1'b0;
        pend.delete();
        dp_act = 0; retry_pend = 0; err_stage = 0; prefer = 0; exp_dv = 0;
        exp_owner = 0; exp_err = 0; exp_rdata = '0; n_acc = 0; n_done = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            // completions from the previous edge
            chk("rnd_done0", req0_done, exp_dv && !exp_owner);
            chk("rnd_done1", req1_done, exp_dv && exp_owner);
            n_done += int'(req0_done) + int'(req1_done);
            if (exp_dv) begin
                chk("rnd_err", exp_owner ? req1_err : req0_err, exp_err);
                chk("rnd_rdata", exp_owner ? req1_rdata : req0_rdata, exp_rdata);
            end
            // address phase shows the oldest unissued transfer unless it is retained
            shown = (pend.size() != 0) && !retry_pend;
            chk("rnd_htrans", HTRANS, shown ? 2'b10 : 2'b00);
            if (shown) begin
                chk("rnd_haddr", HADDR, pend[0].addr);
                chk("rnd_hwrite", HWRITE, pend[0].write);
                chk("rnd_hsize", HSIZE, pend[0].size);
            end
            // requesters
            v0 = (cyc < 1960) && ($urandom_range(0, 2) != 0);
            v1 = (cyc < 1960) && ($urandom_range(0, 2) != 0);
            req0_valid = v0; req0_write = 1'($urandom_range(0, 1));
            req0_addr = $urandom & 32'hFFFF_FFFC; req0_size = 3'($urandom_range(0, 2));
            req0_wdata = $urandom;
            req1_valid = v1; req1_write = 1'($urandom_range(0, 1));
            req1_addr = $urandom & 32'hFFFF_FFFC; req1_size = 3'($urandom_range(0, 2));
            req1_wdata = $urandom;
            // slave response
            first_err = 0;
            if (err_stage) begin
                HREADY = 1'b1; HRESP = 1'b1;
            end else if (dp_act) begin
                case ($urandom_range(0, 7))
                    0:       begin HREADY = 1'b0; HRESP = 1'b1; first_err = 1; end
                    1, 2:    begin HREADY = 1'b0; HRESP = 1'b0; end
                    default: begin HREADY = 1'b1; HRESP = 1'b0; end
                endcase
            end else begin
                HREADY = 1'b1; HRESP = 1'b0;
            end
            HRDATA = $urandom;
            #1;
            free = ((pend.size() == 0) || HREADY) && !retry_pend;
            e0 = v0 && free && (!v1 || prefer == 1'b0);
            e1 = v1 && free && (!v0 || prefer == 1'b1);
            chk("rnd_ready0", req0_ready, e0);
            chk("rnd_ready1", req1_ready, e1);
            // effects of the coming edge
            exp_dv = 0;
            if (HREADY && dp_act) begin
                exp_dv    = 1;
                exp_owner = dp.owner;
                exp_err   = HRESP;
                exp_rdata = dp.write ? '0 : HRDATA;
                if (dp.write) chk("rnd_hwdata", HWDATA, dp.wdata);
                dp_act = 0;
            end
            if (first_err && shown) retry_pend = 1;
            else if (retry_pend && HREADY) retry_pend = 0;
            if (shown && HREADY) begin
                dp = pend.pop_front();
                dp_act = 1;
            end
            if (e0 || e1) begin
                t.owner = e1;
                t.write = e1 ? req1_write : req0_write;
                t.addr  = e1 ? req1_addr  : req0_addr;
                t.size  = e1 ? req1_size  : req0_size;
                t.wdata = e1 ? req1_wdata : req0_wdata;
                pend.push_back(t);
                prefer = ~e1;
                n_acc++;
            end
            err_stage = first_err;
            tick();
        end
        chk("rnd_all_completed", n_done, n_acc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
